// File: rtl/fb_pixel_writer_pkg.sv
// Shared types and constants for the framebuffer pixel writer: FIFO entry
// layout, last-pixel marker and write FSM encoding.
package fb_pixel_writer_pkg;

  typedef struct packed {
    logic [18:0] pixel_id;
    logic [23:0] color;
  } pixel_buffer_entry_t;

  // 640x480 frame: pixel IDs 0..307199.
  localparam logic [18:0] LAST_PIXEL_ID = 19'd307199;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W0_SETUP  = 3'd1,
    ST_W0_STROBE = 3'd2,
    ST_W1_SETUP  = 3'd3,
    ST_W1_STROBE = 3'd4
  } wr_state_e;

  // Each 24-bit pixel occupies two consecutive 16-bit SRAM words.
  function automatic logic [19:0] word_addr(input logic [18:0] pixel_id,
                                            input logic        second_word);
    return {pixel_id, second_word};
  endfunction

endpackage

// File: rtl/ff_ar.sv
// Generic register with asynchronous active-low reset to a parameterised value.
module ff_ar #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) q <= RESET_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pops pixels from a show-ahead FIFO and writes each as two setup/strobe SRAM
// word cycles, yielding the bus to the VGA reader whenever it is idle.
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  pixel_buffer_entry_t pb_data,
  input  logic                pb_empty,
  output logic                pb_re,
  input  logic                vga_req,
  output logic                vga_grant,
  output logic [19:0]         sram_addr,
  output logic [15:0]         sram_dout,
  output logic                sram_dout_en,
  output logic                sram_we_b,
  output logic                frame_done,
  output logic [18:0]         pix_count
);

  wr_state_e           state_q, state_d;
  pixel_buffer_entry_t pix_q, pix_d;
  logic [19:0]         addr_q, addr_d;
  logic [15:0]         dout_q, dout_d;
  logic                dout_en_q, dout_en_d;
  logic                we_b_q, we_b_d;
  logic                done_q, done_d;
  logic [18:0]         pix_count_d;
  logic                is_idle;
  logic                is_last;

  assign is_idle = (state_q == ST_IDLE);
  assign is_last = (pix_q.pixel_id == LAST_PIXEL_ID);

  // Bus arbitration is only decided in IDLE; the VGA side always wins a tie.
  assign vga_grant = rst_b && is_idle && vga_req;
  assign pb_re     = rst_b && is_idle && !vga_req && !pb_empty;

  // Strobe and drive-enable are computed one cycle ahead so they leave flops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    pix_d     = pix_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    we_b_d    = 1'b1;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pb_re) begin
          state_d   = ST_W0_SETUP;
          pix_d     = pb_data;
          addr_d    = word_addr(pb_data.pixel_id, 1'b0);
          dout_d    = pb_data.color[23:8];
          dout_en_d = 1'b1;
        end
      end
      ST_W0_SETUP: begin
        state_d   = ST_W0_STROBE;
        dout_en_d = 1'b1;
        we_b_d    = 1'b0;
      end
      ST_W0_STROBE: begin
        state_d   = ST_W1_SETUP;
        addr_d    = word_addr(pix_q.pixel_id, 1'b1);
        dout_d    = {pix_q.color[7:0], 8'h00};
        dout_en_d = 1'b1;
      end
      ST_W1_SETUP: begin
        state_d   = ST_W1_STROBE;
        dout_en_d = 1'b1;
        we_b_d    = 1'b0;
      end
      ST_W1_STROBE: begin
        state_d = ST_IDLE;
        done_d  = is_last;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-frame IDs still count; only the exact last ID wraps the counter.
  always_comb begin
    pix_count_d = pix_count;
    if (state_q == ST_W1_STROBE) pix_count_d = is_last ? '0 : pix_count + 19'd1;
  end

  ff_ar #(.WIDTH(19), .RESET_VAL('0)) u_pix_count (
    .clk   (clk),
    .rst_b (rst_b),
    .d     (pix_count_d),
    .q     (pix_count)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      pix_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      we_b_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      pix_q     <= pix_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      we_b_q    <= we_b_d;
      done_q    <= done_d;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = dout_en_q;
  assign sram_we_b    = we_b_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_fb_pixel_writer;
  import fb_pixel_writer_pkg::*;

  logic                clk;
  logic                rst_b;
  pixel_buffer_entry_t pb_data;
  logic                pb_empty;
  logic                pb_re;
  logic                vga_req;
  logic                vga_grant;
  logic [19:0]         sram_addr;
  logic [15:0]         sram_dout;
  logic                sram_dout_en;
  logic                sram_we_b;
  logic                frame_done;
  logic [18:0]         pix_count;

  fb_pixel_writer dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .pb_data      (pb_data),
    .pb_empty     (pb_empty),
    .pb_re        (pb_re),
    .vga_req      (vga_req),
    .vga_grant    (vga_grant),
    .sram_addr    (sram_addr),
    .sram_dout    (sram_dout),
    .sram_dout_en (sram_dout_en),
    .sram_we_b    (sram_we_b),
    .frame_done   (frame_done),
    .pix_count    (pix_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and reference model of the expected SRAM traffic.
  pixel_buffer_entry_t fifo[$];
  logic [35:0]         exp_wr[$];
  int                  exp_count;
  int                  exp_done;

  // Observations collected by the monitor at each negedge.
  logic [35:0] wr_q[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          pops, we_low, grants, grant_pop, dones, viol, en_cycles, req_wait;
  int          first_grant, done_cyc, last_strobe_cyc;
  logic        last_en, last_we_b;
  logic [19:0] last_addr;
  logic [15:0] last_dout;

  typedef struct {
    logic [18:0] id;
    logic [23:0] color;
    logic [19:0] a0;
    logic [15:0] d0;
    logic [19:0] a1;
    logic [15:0] d1;
    logic [18:0] cnt;
    int          done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    pb_empty = (fifo.size() == 0);
    pb_data  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    pop_cyc.delete();
    pops = 0; we_low = 0; grants = 0; grant_pop = 0; dones = 0; viol = 0;
    en_cycles = 0; req_wait = 0;
    first_grant = -1; done_cyc = -1; last_strobe_cyc = -1;
    last_en = 1'b0; last_we_b = 1'b1; last_addr = '0; last_dout = '0;
  endtask

  // Model: each pixel becomes two word writes; the exact last ID ends a frame.
  task automatic push_pixel(input logic [18:0] id, input logic [23:0] color);
    pixel_buffer_entry_t p;
    p.pixel_id = id;
    p.color    = color;
    fifo.push_back(p);
    exp_wr.push_back({id, 1'b0, color[23:8]});
    exp_wr.push_back({id, 1'b1, color[7:0], 8'h00});
    if (id == 19'd307199) begin
      exp_count = 0;
      exp_done++;
    end else begin
      exp_count++;
    end
    refresh();
  endtask

  // One clock: sample at negedge, then advance the FIFO just after posedge.
  task automatic cycle();
    logic popped;
    @(negedge clk);
    popped = pb_re;
    if (!sram_we_b) begin
      we_low++;
      last_strobe_cyc = cyc;
      wr_q.push_back({sram_addr, sram_dout});
      if (!sram_dout_en || !last_en || !last_we_b ||
          last_addr != sram_addr || last_dout != sram_dout) viol++;
    end
    if (sram_dout_en) en_cycles++;
    if (pb_re) begin
      pops++;
      pop_cyc.push_back(cyc);
    end
    if (vga_grant) begin
      grants++;
      if (first_grant < 0) first_grant = cyc;
      if (pb_re) grant_pop++;
    end
    if (frame_done) begin
      dones++;
      done_cyc = cyc;
    end
    if (vga_grant !== (vga_req && !sram_dout_en)) viol++;
    if (pb_re !== (!pb_empty && !vga_req && !sram_dout_en)) viol++;
    if (vga_req && !vga_grant) req_wait++;
    else req_wait = 0;
    if (req_wait > 4) viol++;
    last_en = sram_dout_en; last_we_b = sram_we_b;
    last_addr = sram_addr; last_dout = sram_dout;
    @(posedge clk);
    #1;
    if (popped && fifo.size() != 0) void'(fifo.pop_front());
    refresh();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    vga_req = 1'b0;
    fifo.delete();
    exp_wr.delete();
    exp_count = 0;
    exp_done  = 0;
    refresh();
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_wr[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pixel_buffer_entry_t p;
    logic [31:0]         r;
    int                  req_cyc;
    int                  k;

    vecs[0] = '{19'd5,      24'hAABBCC, 20'h0000A, 16'hAABB, 20'h0000B, 16'hCC00, 19'd1, 0};
    vecs[1] = '{19'd0,      24'h123456, 20'h00000, 16'h1234, 20'h00001, 16'h5600, 19'd1, 0};
    vecs[2] = '{19'd307199, 24'hFFFFFF, 20'h95FFE, 16'hFFFF, 20'h95FFF, 16'hFF00, 19'd0, 1};
    vecs[3] = '{19'd307200, 24'h00FF01, 20'h96000, 16'h00FF, 20'h96001, 16'h0100, 19'd1, 0};
    vecs[4] = '{19'h7FFFF,  24'h800001, 20'hFFFFE, 16'h8000, 20'hFFFFF, 16'h0100, 19'd1, 0};
    vecs[5] = '{19'd307198, 24'h0F0F0F, 20'h95FFC, 16'h0F0F, 20'h95FFD, 16'h0F00, 19'd1, 0};

    // Reset state, with a non-empty FIFO and then a VGA request pending.
    rst_b = 1'b1;
    vga_req = 1'b0;
    exp_count = 0;
    exp_done = 0;
    clear_mon();
    p.pixel_id = 19'd9;
    p.color = 24'h010203;
    fifo.push_back(p);
    refresh();
    #2 rst_b = 1'b0;
    #1;
    check("rst_pb_re", pb_re, 1'b0);
    check("rst_we_b", sram_we_b, 1'b1);
    check("rst_dout_en", sram_dout_en, 1'b0);
    check("rst_addr", sram_addr, 20'h0);
    check("rst_dout", sram_dout, 16'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_pix_count", pix_count, 19'd0);
    vga_req = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vga_grant", vga_grant, 1'b0);
    check("rst_pb_re_clk", pb_re, 1'b0);

    // Table of single pixels, each from a fresh reset.
    foreach (vecs[v]) begin
      do_reset();
      p.pixel_id = vecs[v].id;
      p.color    = vecs[v].color;
      fifo.push_back(p);
      refresh();
      run(8);
      check($sformatf("v%0d_pops", v), pops, 1);
      check($sformatf("v%0d_we_low", v), we_low, 2);
      check($sformatf("v%0d_nwr", v), wr_q.size(), 2);
      if (wr_q.size() >= 2) begin
        check($sformatf("v%0d_wr0", v), wr_q[0], {vecs[v].a0, vecs[v].d0});
        check($sformatf("v%0d_wr1", v), wr_q[1], {vecs[v].a1, vecs[v].d1});
      end
      check($sformatf("v%0d_pix_count", v), pix_count, vecs[v].cnt);
      check($sformatf("v%0d_done", v), dones, vecs[v].done);
      check($sformatf("v%0d_proto", v), viol, 0);
    end

    // Back-to-back pixels pop every fifth cycle.
    do_reset();
    push_pixel(19'd100, 24'h111111);
    push_pixel(19'd101, 24'h222222);
    push_pixel(19'd102, 24'h333333);
    run(18);
    check("b2b_pops", pops, 3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap1", pop_cyc[1] - pop_cyc[0], 5);
      check("b2b_gap2", pop_cyc[2] - pop_cyc[1], 5);
    end
    compare_writes("b2b");
    check("b2b_pix_count", pix_count, exp_count);
    check("b2b_proto", viol, 0);

    // VGA request held while pixels wait: granted every cycle, no pops.
    do_reset();
    vga_req = 1'b1;
    push_pixel(19'd7, 24'hCAFE01);
    push_pixel(19'd8, 24'hBEEF02);
    run(10);
    check("vga_grants", grants, 10);
    check("vga_pops", pops, 0);
    vga_req = 1'b0;
    req_cyc = cyc;
    run(12);
    check("vga_resume_nonempty", pop_cyc.size() != 0, 1'b1);
    if (pop_cyc.size() != 0) check("vga_resume_cyc", pop_cyc[0], req_cyc);
    compare_writes("vga");
    check("vga_pix_count", pix_count, exp_count);
    check("vga_proto", viol, 0);

    // VGA request rising in W0_STROBE waits for the pixel to finish.
    do_reset();
    push_pixel(19'd40, 24'h445566);
    push_pixel(19'd41, 24'h778899);
    k = 0;
    while (k < 10 && !(pops == 1 && last_en && last_we_b && we_low == 0)) begin
      cycle();
      k++;
    end
    check("mid_w0_setup_found", (pops == 1 && last_en && last_we_b && we_low == 0), 1'b1);
    vga_req = 1'b1;
    req_cyc = cyc;
    run(10);
    check("mid_first_grant", first_grant, req_cyc + 3);
    check("mid_grant_pop", grant_pop, 0);
    check("mid_pops", pops, 1);
    check("mid_we_low", we_low, 2);
    vga_req = 1'b0;
    run(8);
    compare_writes("mid");
    check("mid_pix_count", pix_count, exp_count);
    check("mid_proto", viol, 0);

    // Frame end: last pixel fires frame_done once and wraps the counter.
    do_reset();
    push_pixel(19'd307198, 24'hABCDEF);
    push_pixel(19'd307199, 24'hFEDCBA);
    run(14);
    check("frame_dones", dones, 1);
    check("frame_done_cyc", done_cyc, last_strobe_cyc + 1);
    check("frame_pix_count", pix_count, 19'd0);
    compare_writes("frame");
    check("frame_proto", viol, 0);

    // Reset asserted in W1_SETUP abandons the write.
    do_reset();
    push_pixel(19'd3, 24'h135790);
    run(6);
    check("rstmid_count_before", pix_count, 19'd1);
    p.pixel_id = 19'd4;
    p.color = 24'h246802;
    fifo.push_back(p);
    refresh();
    k = 0;
    while (k < 10 && we_low < 3) begin
      cycle();
      k++;
    end
    check("rstmid_in_w1_setup", {sram_dout_en, sram_we_b}, 2'b11);
    rst_b = 1'b0;
    #1;
    check("rstmid_we_b", sram_we_b, 1'b1);
    check("rstmid_dout_en", sram_dout_en, 1'b0);
    check("rstmid_pix_count", pix_count, 19'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    run(8);
    check("rstmid_no_strobe", we_low, 0);
    check("rstmid_no_drive", en_cycles, 0);
    check("rstmid_count_after", pix_count, 19'd0);
    vga_req = 1'b1;
    cycle();
    check("rstmid_idle_grant", grants, 1);
    vga_req = 1'b0;

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo.size() < 8) begin
        r = $urandom;
        case ($urandom_range(0, 9))
          0:       push_pixel(19'd307199, r[23:0]);
          1:       push_pixel(19'(307200 + $urandom_range(0, 217087)), r[23:0]);
          default: push_pixel(19'($urandom_range(0, 307198)), r[23:0]);
        endcase
      end
      if ($urandom_range(0, 7) == 0) vga_req = ~vga_req;
      cycle();
    end
    vga_req = 1'b0;
    k = 0;
    while (k < 200 && fifo.size() != 0) begin
      cycle();
      k++;
    end
    run(6);
    check("rnd_drained", fifo.size(), 0);
    compare_writes("rnd");
    check("rnd_pix_count", pix_count, exp_count);
    check("rnd_dones", dones, exp_done);
    check("rnd_grant_pop", grant_pop, 0);
    check("rnd_proto", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 SHALL have the following ports:
  clk  in  1  system clock (50 MHz); all state updates on posedge
  rst_b  in  1  asynchronous active-low reset
  pb_data  in  $bits(pixel_buffer_entry_t)  head of show-ahead pixel FIFO; fields {pixelID[18:0], color[23:0]}
  pb_empty  in  1  pixel FIFO empty
  pb_re  out  1  pop pixel FIFO
  vga_req  in  1  VGA read side requests the SRAM bus
  vga_grant  out  1  SRAM bus handed to VGA read side this cycle
  sram_addr  out  20  SRAM word address
  sram_dout  out  16  write data
  sram_dout_en  out  1  drive sram_io with sram_dout
  sram_we_b  out  1  SRAM write strobe, active-low
  frame_done  out  1  one-cycle pulse when the last pixel of a frame is written
  pix_count  out  19  pixels written in the current frame
REQ-002 SHALL use one clock (clk) and an asynchronous active-low reset (rst_b).

Function
REQ-003 SHALL implement the FSM IDLE, W0_SETUP, W0_STROBE, W1_SETUP, W1_STROBE.
REQ-004 In IDLE, pb_re SHALL be 1 for exactly one cycle iff !pb_empty && !vga_req; pb_data SHALL be latched that same cycle and the FSM SHALL go to W0_SETUP.
REQ-005 In IDLE with vga_req=1, vga_grant SHALL be 1 combinationally, pb_re SHALL be 0, and the FSM SHALL stay in IDLE.
REQ-006 vga_grant SHALL be 0 in every state other than IDLE; the worst-case grant latency from vga_req rising is 4 cycles.
REQ-007 Word address mapping: W0 SHALL use addr {pixelID, 1'b0}; W1 SHALL use addr {pixelID, 1'b1}.
REQ-008 Data mapping: W0 SHALL carry color[23:8]; W1 SHALL carry {color[7:0], 8'h00}.
REQ-009 In each SETUP state, addr and data SHALL be driven with sram_dout_en=1 and sram_we_b=1.
REQ-010 In each STROBE state, addr, data and sram_dout_en=1 SHALL stay stable and sram_we_b=0.
REQ-011 Transitions SHALL be unconditional: W0_SETUP to W0_STROBE to W1_SETUP to W1_STROBE to IDLE, giving 4 cycles per pixel with no mid-pixel preemption.
REQ-012 Outside SETUP/STROBE, sram_dout_en SHALL be 0 and sram_we_b SHALL be 1.
REQ-013 sram_we_b and sram_dout_en SHALL be registered outputs (glitch-free).
REQ-014 On leaving W1_STROBE, pix_count SHALL increment.
REQ-015 If the latched pixelID == 19'd307199, frame_done SHALL pulse in the cycle after W1_STROBE and pix_count SHALL wrap to 0 instead of incrementing.
REQ-016 pixelID values > 307199 SHALL still be written; their pixels SHALL count but SHALL NOT fire frame_done.
REQ-017 A back-to-back pixel SHALL be popable in the IDLE cycle immediately following W1_STROBE.

Reset
REQ-018 On rst_b=0, asynchronously: state=IDLE, pb_re=0, vga_grant=0, sram_we_b=1, sram_dout_en=0, sram_addr=0, sram_dout=0, frame_done=0, pix_count=0.
REQ-019 Reset asserted mid-pixel SHALL abandon that write; the popped pixel is lost and no strobe SHALL follow release.
REQ-020 After reset release, the first pop SHALL occur no earlier than the first posedge with rst_b=1.

Structure
REQ-021 pixel_buffer_entry_t, the 307199 last-pixel constant and the FSM state enum SHALL live in the shared package.
REQ-022 Counters SHALL use the existing ff_ar register primitive; no other sub-module is required.

Verification
REQ-023 Single pixel: pixelID=5, color=24'hAABBCC, vga_req=0. Required response:
  - one pb_re pulse;
  - writes 0x0000A to 16'hAABB, then 0x0000B to 16'hCC00;
  - sram_we_b low exactly 2 cycles total;
  - pix_count=1.
REQ-024 Back-to-back: FIFO holds 3 pixels. Required response:
  - pb_re pulses spaced 5 cycles apart;
  - 6 writes in order;
  - pix_count=3.
REQ-025 VGA priority: vga_req=1 held while FIFO non-empty. Required response:
  - vga_grant=1 and pb_re=0 every cycle;
  - pops resume the first cycle after vga_req drops.
REQ-026 Request mid-pixel: vga_req rises in W0_STROBE. Required response:
  - pixel completes;
  - vga_grant first asserts 3 cycles later;
  - no pop while granted.
REQ-027 Frame end: pixels 307198 and 307199 written. Required response:
  - frame_done pulses once after the second pixel;
  - pix_count=0 afterwards.
REQ-028 Reset in W1_SETUP. Required response:
  - sram_we_b=1 and sram_dout_en=0 immediately;
  - state IDLE;
  - pix_count=0;
  - no strobe after release.
